cr_clic_req_ctrl: RTL and testbench

CR_CLIC_REQ_CTRL -- requirements
Module: cr_clic_req_ctrl

---
 rtl/cr_clic_req_ctrl.sv | 139 +++++++++++++
 tb/tb_cr_clic_req_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_clic_req_ctrl.sv
// CLIC request controller: qualifies the arbiter winner against threshold/current level,
// presents it to the CPU and issues a pending-clear on ack. Optional macro: CLIC_REQ_CTRL_SAMPLE_EN.
//   state  | meaning
//   IDLE   | nothing presented, waiting for an eligible winner
//   SAMPLE | winner captured, waiting for it to be stable for one more cycle (macro only)
//   PEND   | interrupt presented to CPU (vld high)
//   ACK    | CPU took it; clear pulse issued, holding off for ACK_HOLD cycles
module cr_clic_req_ctrl #(
  parameter int ID_WIDTH = 12,
  parameter int ACK_HOLD = 2
) (
  input  logic                out_clk,
  input  logic                cpurst_b,
  input  logic                arb_ctrl_int_req,
  input  logic [ID_WIDTH-1:0] arb_ctrl_int_id,
  input  logic [7:0]          arb_ctrl_int_il,
  input  logic                arb_ctrl_int_hv,
  input  logic                arb_ctrl_int_mode,
  input  logic [7:0]          cpu_clic_mintthresh,
  input  logic [7:0]          cpu_clic_cur_il,
  input  logic                cpu_clic_int_ack,
  output logic                clic_cpu_int_vld,
  output logic [ID_WIDTH-1:0] clic_cpu_int_id,
  output logic [7:0]          clic_cpu_int_il,
  output logic                clic_cpu_int_hv,
  output logic                clic_cpu_int_mode,
  output logic                clic_kid_clr_vld,
  output logic [ID_WIDTH-1:0] clic_kid_clr_id,
  output logic                out_clk_en
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
`ifdef CLIC_REQ_CTRL_SAMPLE_EN
  localparam logic [1:0] ST_SAMPLE = 2'd1;
`endif
  localparam logic [1:0] ST_PEND   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          il_q, il_d;
  logic                hv_q, hv_d;
  logic                mode_q, mode_d;
  logic                clr_vld_q, clr_vld_d;
  logic [ID_WIDTH-1:0] clr_id_q, clr_id_d;
  logic [7:0]          thresh;
  logic                eligible;
  logic                capture;

  assign thresh   = (cpu_clic_mintthresh > cpu_clic_cur_il) ? cpu_clic_mintthresh : cpu_clic_cur_il;
  assign eligible = arb_ctrl_int_req && (arb_ctrl_int_il != 8'd0) && (arb_ctrl_int_il > thresh);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_vld_d = 1'b0;
    clr_id_d  = clr_id_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          capture = 1'b1;
`ifdef CLIC_REQ_CTRL_SAMPLE_EN
          state_d = ST_SAMPLE;
`else
          state_d = ST_PEND;
`endif
        end
      end
`ifdef CLIC_REQ_CTRL_SAMPLE_EN
      ST_SAMPLE: begin
        if (!eligible)                   state_d = ST_IDLE;
        else if (arb_ctrl_int_id == id_q) state_d = ST_PEND;
        else                             capture = 1'b1;
      end
`endif
      ST_PEND: begin
        // ack has priority over withdrawal/preemption: the presented ID is what gets cleared
        if (cpu_clic_int_ack) begin
          state_d   = ST_ACK;
          clr_vld_d = 1'b1;
          clr_id_d  = id_q;
          cnt_d     = 2'(ACK_HOLD - 1);
        end else if (!eligible) begin
          state_d = ST_IDLE;
        end else if ((arb_ctrl_int_id != id_q) || (arb_ctrl_int_il != il_q)) begin
          capture = 1'b1;
        end
      end
      ST_ACK: begin
        if (cnt_q == 2'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    id_d   = capture ? arb_ctrl_int_id   : id_q;
    il_d   = capture ? arb_ctrl_int_il   : il_q;
    hv_d   = capture ? arb_ctrl_int_hv   : hv_q;
    mode_d = capture ? arb_ctrl_int_mode : mode_q;
    vld_d  = (state_d == ST_PEND);
  end

  always_ff @(posedge out_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      vld_q     <= 1'b0;
      id_q      <= '0;
      il_q      <= 8'd0;
      hv_q      <= 1'b0;
      mode_q    <= 1'b0;
      clr_vld_q <= 1'b0;
      clr_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      id_q      <= id_d;
      il_q      <= il_d;
      hv_q      <= hv_d;
      mode_q    <= mode_d;
      clr_vld_q <= clr_vld_d;
      clr_id_q  <= clr_id_d;
    end
  end

  assign clic_cpu_int_vld  = vld_q;
  assign clic_cpu_int_id   = id_q;
  assign clic_cpu_int_il   = il_q;
  assign clic_cpu_int_hv   = hv_q;
  assign clic_cpu_int_mode = mode_q;
  assign clic_kid_clr_vld  = clr_vld_q;
  assign clic_kid_clr_id   = clr_id_q;
  assign out_clk_en        = (state_q != ST_IDLE) || arb_ctrl_int_req;

endmodule

// File: tb/tb_cr_clic_req_ctrl.sv
// Scoreboard bench for cr_clic_req_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of the request controller.
module tb_cr_clic_req_ctrl;
  localparam int IDW  = 12;
  localparam int HOLD = 2;

  logic           out_clk = 1'b0;
  logic           cpurst_b;
  logic           req;
  logic [IDW-1:0] id;
  logic [7:0]     il;
  logic           hv, mode;
  logic [7:0]     thresh, cur_il;
  logic           ack;
  logic           vld, hv_o, mode_o, clr_vld, clk_en;
  logic [IDW-1:0] id_o, clr_id;
  logic [7:0]     il_o;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  typedef struct {
    logic           vld;
    logic [IDW-1:0] id;
    logic [7:0]     il;
    logic           hv;
    logic           mode;
    logic           clr_vld;
    logic [IDW-1:0] clr_id;
    logic           clk_en;
  } exp_t;
  exp_t sb_q[$];

  // model state: what is presented, whether we are confirming a capture, ACK cycles left
  bit             m_present, m_sampling;
  int             m_ack_left;
  logic [IDW-1:0] m_id, m_clr_id;
  logic [7:0]     m_il;
  logic           m_hv, m_mode, m_clr;

  cr_clic_req_ctrl #(.ID_WIDTH(IDW), .ACK_HOLD(HOLD)) dut (
    .out_clk(out_clk), .cpurst_b(cpurst_b),
    .arb_ctrl_int_req(req), .arb_ctrl_int_id(id), .arb_ctrl_int_il(il),
    .arb_ctrl_int_hv(hv), .arb_ctrl_int_mode(mode),
    .cpu_clic_mintthresh(thresh), .cpu_clic_cur_il(cur_il), .cpu_clic_int_ack(ack),
    .clic_cpu_int_vld(vld), .clic_cpu_int_id(id_o), .clic_cpu_int_il(il_o),
    .clic_cpu_int_hv(hv_o), .clic_cpu_int_mode(mode_o),
    .clic_kid_clr_vld(clr_vld), .clic_kid_clr_id(clr_id), .out_clk_en(clk_en)
  );

  always #5 out_clk = ~out_clk;

  task automatic model_capture();
    m_id = id; m_il = il; m_hv = hv; m_mode = mode;
  endtask

  task automatic model_step();
    int  lim;
    bit  elig;
    lim  = (int'(thresh) > int'(cur_il)) ? int'(thresh) : int'(cur_il);
    elig = req && (int'(il) > lim) && (il != 0);
    m_clr = 1'b0;
    if (!cpurst_b) begin
      m_present = 0; m_sampling = 0; m_ack_left = 0;
      m_id = '0; m_il = '0; m_hv = 0; m_mode = 0; m_clr_id = '0;
    end else if (m_ack_left > 0) begin
      m_ack_left = m_ack_left - 1;
    end else if (m_present) begin
      if (ack) begin
        m_clr = 1'b1; m_clr_id = m_id; m_present = 0; m_ack_left = HOLD;
      end else if (!elig) begin
        m_present = 0;
      end else if (id != m_id || il != m_il) begin
        model_capture();
      end
    end else if (m_sampling) begin
      if (!elig) m_sampling = 0;
      else if (id == m_id) begin m_sampling = 0; m_present = 1; end
      else model_capture();
    end else if (elig) begin
      model_capture();
`ifdef CLIC_REQ_CTRL_SAMPLE_EN
      m_sampling = 1;
`else
      m_present = 1;
`endif
    end
  endtask

  // called right after inputs change at a falling edge; returns at the next falling edge
  task automatic tick();
    exp_t e;
    if (!cpurst_b) begin
      #1;
      checks++;
      if ({vld, id_o, il_o, hv_o, mode_o, clr_vld, clr_id} !== '0) begin
        failures++;
        $display("FAIL rst_async t=%0t got vld=%b id=%0h il=%0h hv=%b mode=%b clr=%b clr_id=%0h, required all zero",
                 $time, vld, id_o, il_o, hv_o, mode_o, clr_vld, clr_id);
      end
    end
    model_step();
    e.vld = m_present; e.id = m_id; e.il = m_il; e.hv = m_hv; e.mode = m_mode;
    e.clr_vld = m_clr; e.clr_id = m_clr_id;
    e.clk_en = m_present || m_sampling || (m_ack_left > 0) || req;
    sb_q.push_back(e);
    started = 1'b1;
    @(negedge out_clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge out_clk);
      #2;
      if (started) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty t=%0t no expected entry for output sample", $time);
        end else begin
          e = sb_q.pop_front();
          if (vld !== e.vld || id_o !== e.id || il_o !== e.il || hv_o !== e.hv || mode_o !== e.mode ||
              clr_vld !== e.clr_vld || clr_id !== e.clr_id || clk_en !== e.clk_en) begin
            failures++;
            $display("FAIL sb_cycle t=%0t got vld=%b id=%0h il=%0h hv=%b mode=%b clr=%b clr_id=%0h en=%b required vld=%b id=%0h il=%0h hv=%b mode=%b clr=%b clr_id=%0h en=%b",
                     $time, vld, id_o, il_o, hv_o, mode_o, clr_vld, clr_id, clk_en,
                     e.vld, e.id, e.il, e.hv, e.mode, e.clr_vld, e.clr_id, e.clk_en);
          end
        end
      end
    end
  end

  task automatic set_arb(input logic r, input logic [IDW-1:0] i, input logic [7:0] l);
    req = r; id = i; il = l;
  endtask

  task automatic reach_pend_id5();
    set_arb(1, 12'd5, 8'h40);
    repeat (3) tick();
  endtask

  initial begin : driver
    int k;
    cpurst_b = 0; req = 0; id = '0; il = '0; hv = 0; mode = 0;
    thresh = 8'h20; cur_il = 8'h00; ack = 0;
    @(negedge out_clk);
    tick();
    cpurst_b = 1;
    tick();

    // entry latency, ack with clear pulse, ACK hold
    reach_pend_id5();
    hv = 1; mode = 1;
    ack = 1; tick();
    ack = 0; set_arb(0, 12'd5, 8'h40); hv = 0; mode = 0;
    repeat (4) tick();

    // preemption in PEND to a different id/level
    reach_pend_id5();
    set_arb(1, 12'd9, 8'h80); tick(); tick();

    // masking by current level, without and with ack
    reach_pend_id5();
    cur_il = 8'h40; tick(); tick();
    cur_il = 8'h00; reach_pend_id5();
    cur_il = 8'h40; ack = 1; tick();
    ack = 0; cur_il = 8'h00; repeat (3) tick();
    set_arb(0, 12'd5, 8'h40); tick(); tick();

    // ack outside PEND is ignored; level 0 and level == threshold are not eligible
    ack = 1; tick(); ack = 0;
    set_arb(1, 12'd3, 8'h00); tick(); tick();
    set_arb(1, 12'd3, 8'h20); tick(); tick();
    set_arb(1, 12'd3, 8'h21); repeat (3) tick();
    set_arb(0, 12'd3, 8'h21); tick(); tick();

    // reset in first ACK cycle, then re-entry
    reach_pend_id5();
    ack = 1; tick(); ack = 0;
    cpurst_b = 0; tick();
    cpurst_b = 1; repeat (4) tick();
    set_arb(0, 12'd0, 8'h00); tick();

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = ($urandom_range(0, 7) != 0);
        k = $urandom_range(0, 3);
        id = (k == 0) ? 12'd5 : (k == 1) ? 12'd9 : (k == 2) ? 12'd1 : 12'($urandom);
        k = $urandom_range(0, 4);
        il = (k == 0) ? 8'h00 : (k == 1) ? 8'h10 : (k == 2) ? 8'h40 : (k == 3) ? 8'h80 : 8'($urandom);
        hv = 1'($urandom); mode = 1'($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        thresh = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h40;
        cur_il = ($urandom_range(0, 2) == 0) ? 8'h40 : 8'h00;
      end
      ack = ($urandom_range(0, 3) == 0);
      cpurst_b = ($urandom_range(0, 199) != 0);
      tick();
    end
    cpurst_b = 1; ack = 0;
    tick();

    for (int w = 0; w < 5 && sb_q.size() != 0; w++) @(negedge out_clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain got %0d entries left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
